// File: rtl/pet_pkg.sv
// Shared mood codes, channel indices and the mood classifier
// for the pet need engine.
package pet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NEUTRAL = 3'd1,
        ST_NEED    = 3'd2,
        ST_SAD     = 3'd3,
        ST_ACTIVE  = 3'd4,
        ST_DEATH   = 3'd5
    } mood_e;

    localparam int unsigned PET_LVL_W     = 3;
    localparam int unsigned PET_MAX_NEEDS = 8;

    localparam int unsigned CH_ENERGY = 0;
    localparam int unsigned CH_HUNGER = 1;
    localparam int unsigned CH_FUN    = 2;

    // Mood from per-channel flags, zero-padded to PET_MAX_NEEDS.
    function automatic mood_e mood_class(
        input logic [PET_MAX_NEEDS-1:0] low,
        input logic [PET_MAX_NEEDS-1:0] below_max
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(PET_MAX_NEEDS); i++) begin
            n += 32'(low[i]);
        end
        if (n >= 2)          return ST_SAD;
        if (n == 1)          return ST_NEED;
        if (|below_max)      return ST_NEUTRAL;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/need_channel.sv
// One need channel: saturating level with decay and recovery counters.
// Ports: clk_i, rst_i, tick_i, freeze_i, recov_i, clr_rcnt_i, set_i,
//        set_lvl_i, boost_i in; level_o out.
module need_channel
    import pet_pkg::*;
#(
    parameter int unsigned LVL_W   = PET_LVL_W,
    parameter int unsigned LVL_MAX = 5,
    parameter int unsigned DECAY   = 1,
    parameter int unsigned RECOV   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             freeze_i,
    input  logic             recov_i,
    input  logic             clr_rcnt_i,
    input  logic             set_i,
    input  logic [LVL_W-1:0] set_lvl_i,
    input  logic             boost_i,
    output logic [LVL_W-1:0] level_o
);

    localparam logic [LVL_W-1:0] MAXV  = LVL_W'(LVL_MAX);
    localparam logic [LVL_W:0]   MAXW  = (LVL_W+1)'(LVL_MAX);
    localparam logic [31:0]      DLAST = 32'(DECAY - 1);
    localparam logic [31:0]      RLAST = 32'(RECOV - 1);

    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      dcnt_q, dcnt_d;
    logic [31:0]      rcnt_q, rcnt_d;
    logic             dec, inc;
    logic [LVL_W:0]   sum, up;

    always_comb begin
        dcnt_d = dcnt_q;
        rcnt_d = rcnt_q;
        dec    = 1'b0;
        inc    = 1'b0;
        if (tick_i && !recov_i) begin
            if (dcnt_q == DLAST) begin
                dcnt_d = '0;
                dec    = 1'b1;
            end else begin
                dcnt_d = dcnt_q + 32'd1;
            end
        end
        if (tick_i && recov_i) begin
            if (rcnt_q == RLAST) begin
                rcnt_d = '0;
                inc    = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 32'd1;
            end
        end
        if (clr_rcnt_i) begin
            rcnt_d = '0;
        end
        // Saturate the increments first so a boost at max
        // still lets a same-cycle decay take effect.
        sum = {1'b0, level_q}
            + {{LVL_W{1'b0}}, inc}
            + {{LVL_W{1'b0}}, boost_i};
        up  = (sum > MAXW) ? MAXW : sum;
        if (dec && up != '0) begin
            level_d = up[LVL_W-1:0] - LVL_W'(1);
        end else begin
            level_d = up[LVL_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= MAXV;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
        end else if (set_i) begin
            level_q <= set_lvl_i;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
        end else if (!freeze_i) begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pet_need_engine.sv
// Pet need engine: tick divider, N need channels and the mood FSM.
// Ports: clk_i, rst_i, act_req_i, act_stop_i, boost_i, revive_i in;
//        state_o, levels_o, low_mask_o, act_ch_o, tick_o out.
// PET_TEST_EN adds test_load_i / test_levels_i for a direct level load.
module pet_need_engine
    import pet_pkg::*;
#(
    parameter int unsigned NUM_NEEDS = 3,
    parameter int unsigned LVL_W     = PET_LVL_W,
    parameter int unsigned LVL_MAX   = 5,
    parameter int unsigned LOW_THR   = 2,
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [32*NUM_NEEDS-1:0] DECAY_TICKS =
        {32'd4, 32'd1, 32'd2},
    parameter int unsigned RECOV_TICKS = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_NEEDS-1:0]       act_req_i,
    input  logic                       act_stop_i,
    input  logic [NUM_NEEDS-1:0]       boost_i,
    input  logic                       revive_i,
`ifdef PET_TEST_EN
    input  logic                       test_load_i,
    input  logic [NUM_NEEDS*LVL_W-1:0] test_levels_i,
`endif
    output logic [2:0]                 state_o,
    output logic [NUM_NEEDS*LVL_W-1:0] levels_o,
    output logic [NUM_NEEDS-1:0]       low_mask_o,
    output logic [2:0]                 act_ch_o,
    output logic                       tick_o
);

    localparam logic [LVL_W-1:0] MAXV     = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] LOWV     = LVL_W'(LOW_THR);
    localparam logic [31:0]      DIV_LAST = 32'(TICK_DIV - 1);

    logic [31:0]          div_q, div_d;
    logic                 tick;
    mood_e                state_q, state_d;
    logic [2:0]           act_ch_q, act_ch_d;
    logic [LVL_W-1:0]     lvl     [NUM_NEEDS];
    logic [LVL_W-1:0]     set_lvl [NUM_NEEDS];
    logic [NUM_NEEDS-1:0] low, below_max, zero;
    logic [NUM_NEEDS-1:0] recov, clr_rcnt;
    logic                 any_zero, freeze, set, enter;
    logic                 act_full, req_open;
    logic [2:0]           req_ch;
    mood_e                mood;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 32'd1;

    for (genvar i = 0; i < int'(NUM_NEEDS); i++) begin : g_ch
        need_channel #(
            .LVL_W   (LVL_W),
            .LVL_MAX (LVL_MAX),
            .DECAY   (DECAY_TICKS[32*i +: 32]),
            .RECOV   (RECOV_TICKS)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .tick_i     (tick),
            .freeze_i   (freeze),
            .recov_i    (recov[i]),
            .clr_rcnt_i (clr_rcnt[i]),
            .set_i      (set),
            .set_lvl_i  (set_lvl[i]),
            .boost_i    (boost_i[i]),
            .level_o    (lvl[i])
        );
        assign levels_o[i*LVL_W +: LVL_W] = lvl[i];
        assign low[i]       = (lvl[i] <= LOWV);
        assign below_max[i] = (lvl[i] != MAXV);
        assign zero[i]      = (lvl[i] == '0);
        assign recov[i]     = (state_q == ST_ACTIVE)
                            && (act_ch_q == 3'(i));
        assign clr_rcnt[i]  = enter && (req_ch == 3'(i));
    end

    assign any_zero = |zero;
    // Levels stop as soon as one hits zero: DEATH is then certain.
    assign freeze   = any_zero || (state_q == ST_DEATH);
    assign mood     = mood_class(PET_MAX_NEEDS'(low),
                                 PET_MAX_NEEDS'(below_max));

    // Lowest set request bit wins.
    always_comb begin
        req_ch   = '0;
        req_open = 1'b0;
        act_full = 1'b0;
        for (int i = int'(NUM_NEEDS) - 1; i >= 0; i--) begin
            if (act_req_i[i]) begin
                req_ch   = 3'(i);
                req_open = below_max[i];
            end
        end
        for (int i = 0; i < int'(NUM_NEEDS); i++) begin
            if (act_ch_q == 3'(i)) begin
                act_full = !below_max[i];
            end
        end
    end

    always_comb begin
        state_d  = mood;
        act_ch_d = act_ch_q;
        enter    = 1'b0;
        set      = 1'b0;
        for (int i = 0; i < int'(NUM_NEEDS); i++) begin
            set_lvl[i] = MAXV;
        end
        if (state_q == ST_DEATH && revive_i) begin
            state_d = ST_IDLE;
            set     = 1'b1;
        end else if (any_zero) begin
            state_d = ST_DEATH;
        end else if (state_q == ST_DEATH) begin
            state_d = mood;
        end else if (state_q == ST_ACTIVE) begin
            if (!(act_stop_i || act_full)) begin
                state_d = ST_ACTIVE;
            end
        end else if (|act_req_i) begin
            act_ch_d = req_ch;
            if (req_open) begin
                state_d = ST_ACTIVE;
                enter   = 1'b1;
            end
        end
`ifdef PET_TEST_EN
        if (test_load_i) begin
            set = 1'b1;
            for (int i = 0; i < int'(NUM_NEEDS); i++) begin
                set_lvl[i] = test_levels_i[i*LVL_W +: LVL_W];
                if (set_lvl[i] > MAXV) begin
                    set_lvl[i] = MAXV;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q    <= '0;
            state_q  <= ST_IDLE;
            act_ch_q <= '0;
        end else begin
            div_q    <= div_d;
            state_q  <= state_d;
            act_ch_q <= act_ch_d;
        end
    end

    assign state_o    = state_q;
    assign low_mask_o = low;
    assign act_ch_o   = act_ch_q;
    assign tick_o     = tick;

endmodule
